// File: rtl/play_controller_pkg.sv
// play_controller_pkg
// Shared definitions for the rhythm-game play controller:
//   - 4-bit key / target position codes (none, Q..C)
//   - controller state encoding
//   - default chart length
//   - saturating increment helpers for the score and combo counters
package play_controller_pkg;

   localparam logic [3:0] POS_NONE = 4'd0;
   localparam logic [3:0] POS_Q    = 4'd1;
   localparam logic [3:0] POS_W    = 4'd2;
   localparam logic [3:0] POS_E    = 4'd3;
   localparam logic [3:0] POS_A    = 4'd4;
   localparam logic [3:0] POS_S    = 4'd5;
   localparam logic [3:0] POS_D    = 4'd6;
   localparam logic [3:0] POS_Z    = 4'd7;
   localparam logic [3:0] POS_X    = 4'd8;
   localparam logic [3:0] POS_C    = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int STEPS_DEFAULT = 160;

   // Score counter increment, sticking at 1023.
   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      if (v == 10'd1023) begin
         return v;
      end else begin
         return v + 10'd1;
      end
   endfunction

   // Combo counter increment, sticking at 255.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'd255) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

endpackage

// File: rtl/play_controller_chart_rom.sv
// chart_rom
// Purely combinational chart lookup: 20 groups of 8 identical steps.
// Ports:
//   step  in  8  step index (indices past the chart return none)
//   code  out 4  target position code for that step
module chart_rom
   import play_controller_pkg::*;
(
   input  logic [7:0] step,
   output logic [3:0] code
);

   logic [7:0] group;

   assign group = step >> 3;

   // Group-to-code table.
   always_comb begin
      code = POS_NONE;
      case (group)
         8'd0:    code = POS_Q;
         8'd1:    code = POS_W;
         8'd2:    code = POS_E;
         8'd3:    code = POS_A;
         8'd4:    code = POS_S;
         8'd5:    code = POS_D;
         8'd6:    code = POS_Z;
         8'd7:    code = POS_X;
         8'd8:    code = POS_C;
         8'd9:    code = POS_NONE;
         8'd10:   code = POS_Q;
         8'd11:   code = POS_A;
         8'd12:   code = POS_Z;
         8'd13:   code = POS_W;
         8'd14:   code = POS_S;
         8'd15:   code = POS_X;
         8'd16:   code = POS_E;
         8'd17:   code = POS_D;
         8'd18:   code = POS_C;
         8'd19:   code = POS_NONE;
         default: code = POS_NONE;
      endcase
   end

endmodule

// File: rtl/play_controller.sv
// play_controller
// Steps through a fixed chart, one step every TICK_DIV clocks, and judges
// player key presses against the current step's target.
// Ports:
//   clk, rst_n (synchronous, active low)
//   start      in  1   pulse: begin/restart a run from IDLE or DONE
//   pause      in  1   level: freeze the run while high
//   key_valid  in  1   pulse: key press, code on key_pos
//   key_pos    in  4   pressed key code (1..9)
//   pos_cur    out 4   current target code, 0 outside PLAY/PAUSE
//   step       out 8   current step index
//   hit, miss  out 1   registered judgement pulses
//   score      out 10  hit count (saturating)
//   combo      out 8   consecutive hits (saturating)
//   state      out 2   IDLE/PLAY/PAUSE/DONE
module play_controller
   import play_controller_pkg::*;
#(
   parameter int TICK_DIV = 25000000,
   parameter int STEPS    = STEPS_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic       key_valid,
   input  logic [3:0] key_pos,
   output logic [3:0] pos_cur,
   output logic [7:0] step,
   output logic       hit,
   output logic       miss,
   output logic [9:0] score,
   output logic [7:0] combo,
   output logic [1:0] state
);

   localparam int               DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1'b1);
   localparam logic [7:0]       STEP_LAST = 8'(STEPS - 1);

   state_t           cur_state;
   state_t           next_state;
   logic [DIV_W-1:0] div;
   logic             judged;
   logic [3:0]       chart_code;
   logic             tick;
   logic             run_start;
   logic             judge;
   logic             key_hit;
   logic             any_miss;

   chart_rom u_chart_rom (
      .step (step),
      .code (chart_code)
   );

   assign state = cur_state;

   // Target is only visible while a run is active.
   always_comb begin
      pos_cur = POS_NONE;
      if ((cur_state == ST_PLAY) || (cur_state == ST_PAUSE)) begin
         pos_cur = chart_code;
      end else begin
         pos_cur = POS_NONE;
      end
   end

   // Step timing and judgement decisions for this cycle.
   always_comb begin
      tick      = (cur_state == ST_PLAY) && (div == DIV_LAST);
      run_start = start && ((cur_state == ST_IDLE) || (cur_state == ST_DONE));
      judge     = (cur_state == ST_PLAY) && key_valid && !judged;
      key_hit   = judge && (key_pos == pos_cur) && (pos_cur != POS_NONE);
      // A key judged on the tick cycle pre-empts the end-of-step miss.
      any_miss  = (judge && !key_hit) ||
                  (tick && !judged && !judge && (pos_cur != POS_NONE));
   end

   // Next-state logic.
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               next_state = ST_PLAY;
            end else begin
               next_state = cur_state;
            end
         end
         ST_PLAY: begin
            if (tick && (step == STEP_LAST)) begin
               next_state = ST_DONE;
            end else if (pause) begin
               next_state = ST_PAUSE;
            end else begin
               next_state = ST_PLAY;
            end
         end
         ST_PAUSE: begin
            if (!pause) begin
               next_state = ST_PLAY;
            end else begin
               next_state = ST_PAUSE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_state <= ST_IDLE;
      end else begin
         cur_state <= next_state;
      end
   end

   // Divider, step, judged flag, counters and judgement pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div    <= '0;
         step   <= 8'd0;
         judged <= 1'b0;
         score  <= 10'd0;
         combo  <= 8'd0;
         hit    <= 1'b0;
         miss   <= 1'b0;
      end else begin
         hit  <= key_hit;
         miss <= any_miss;
         if (run_start) begin
            div    <= '0;
            step   <= 8'd0;
            judged <= 1'b0;
            score  <= 10'd0;
            combo  <= 8'd0;
         end else if (cur_state == ST_PLAY) begin
            if (key_hit) begin
               score <= sat_inc10(score);
               combo <= sat_inc8(combo);
            end else if (any_miss) begin
               combo <= 8'd0;
            end
            if (tick) begin
               div    <= '0;
               step   <= step + 8'd1;
               judged <= 1'b0;
            end else begin
               div    <= div + DIV_ONE;
               judged <= judged | judge;
            end
         end
      end
   end

endmodule
